// File: rtl/frame_dispatch_ctrl.sv
// Frame dispatch sequencer: pops a 140-bit frame record, validates it and streams
// its payload as 16-bit words to one of eight channels under valid/ready.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a record; error pulses are shown here
// S_FETCH | one-cycle FIFO pop strobe
// S_LATCH | record on fifo_dout; capture and validate it
// S_SEND  | present the top payload word to the selected channel
// S_DONE  | one-cycle frame_done pulse
module frame_dispatch_ctrl #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         fifo_empty,
  output logic         fifo_rd_en,
  input  logic [139:0] fifo_dout,
  input  logic [7:0]   ch_ready,
  output logic [15:0]  dout,
  output logic [7:0]   dout_valid,
  output logic         frame_done,
  output logic         sel_err,
  output logic         timeout_err,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam bit               TO_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  state_t         state_q, state_d;
  logic [127:0]   payload_q, payload_d;
  logic [7:0]     chan_q, chan_d;
  logic [3:0]     wcnt_q, wcnt_d;
  logic [CNT_W-1:0] stall_q, stall_d, stall_inc;

  logic           fifo_rd_en_q, fifo_rd_en_d;
  logic [15:0]    dout_q, dout_d;
  logic [7:0]     dout_valid_q, dout_valid_d;
  logic           frame_done_q, frame_done_d;
  logic           sel_err_q, sel_err_d;
  logic           timeout_err_q, timeout_err_d;
  logic           busy_q, busy_d;

  logic [7:0]     rec_ch;
  logic [3:0]     rec_len;
  logic           rec_valid;
  logic           xfer;

  assign rec_ch    = fifo_dout[11:4];
  assign rec_len   = fifo_dout[3:0];
  assign rec_valid = (rec_ch != 8'd0) && ((rec_ch & (rec_ch - 8'd1)) == 8'd0) &&
                     (rec_len != 4'd0) && (rec_len <= 4'd8);
  assign xfer      = |(ch_ready & chan_q);
  assign stall_inc = stall_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    payload_d     = payload_q;
    chan_d        = chan_q;
    wcnt_d        = wcnt_q;
    stall_d       = stall_q;
    sel_err_d     = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        payload_d = fifo_dout[139:12];
        chan_d    = rec_ch;
        wcnt_d    = rec_len;
        stall_d   = '0;
        if (rec_valid) begin
          state_d = S_SEND;
        end else begin
          state_d   = S_IDLE;
          sel_err_d = 1'b1;
        end
      end
      S_SEND: begin
        if (xfer) begin
          payload_d = {payload_q[111:0], 16'h0000};
          wcnt_d    = wcnt_q - 4'd1;
          stall_d   = '0;
          if (wcnt_q == 4'd1) state_d = S_DONE;
        end else begin
          stall_d = stall_inc;
          // Abandon the frame once the channel has stalled TIMEOUT cycles in a row.
          if (TO_EN && (stall_inc == TO_CNT)) begin
            state_d       = S_IDLE;
            timeout_err_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    fifo_rd_en_d = (state_d == S_FETCH);
    dout_valid_d = (state_d == S_SEND) ? chan_d : 8'd0;
    dout_d       = (state_d == S_SEND) ? payload_d[127:112] : 16'd0;
    frame_done_d = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q       <= S_IDLE;
      payload_q     <= '0;
      chan_q        <= '0;
      wcnt_q        <= '0;
      stall_q       <= '0;
      fifo_rd_en_q  <= 1'b0;
      dout_q        <= '0;
      dout_valid_q  <= '0;
      frame_done_q  <= 1'b0;
      sel_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      payload_q     <= payload_d;
      chan_q        <= chan_d;
      wcnt_q        <= wcnt_d;
      stall_q       <= stall_d;
      fifo_rd_en_q  <= fifo_rd_en_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      frame_done_q  <= frame_done_d;
      sel_err_q     <= sel_err_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
    end
  end

  assign fifo_rd_en  = fifo_rd_en_q;
  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign frame_done  = frame_done_q;
  assign sel_err     = sel_err_q;
  assign timeout_err = timeout_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_frame_dispatch_ctrl.sv
// Bench for frame_dispatch_ctrl: FIFO model plus a per-frame reference model that
// predicts every valid cycle, the terminating pulse and its timing.
module tb_frame_dispatch_ctrl;

  localparam int TB_TIMEOUT = 4;

  logic         clk_in = 1'b0;
  logic         rst;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [139:0] fifo_dout;
  logic [7:0]   ch_ready;
  logic [15:0]  dout;
  logic [7:0]   dout_valid;
  logic         frame_done;
  logic         sel_err;
  logic         timeout_err;
  logic         busy;

  frame_dispatch_ctrl #(.TIMEOUT(TB_TIMEOUT), .CNT_W(16)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_dout   (fifo_dout),
    .ch_ready    (ch_ready),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .frame_done  (frame_done),
    .sel_err     (sel_err),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 clk_in = ~clk_in;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [139:0] fq[$];
  logic         rd_prev = 1'b0;
  logic [7:0]   rdy_pat [64];
  int           send_idx;

  // per-frame observation log
  int          rd_cyc[$];
  logic [23:0] vq[$];
  int          first_v, last_v, vcount;
  int          n_done, n_sel, n_to, n_end, end_cyc;
  logic        busy_at_end;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    rd_cyc.delete();
    vq.delete();
    first_v = -1; last_v = -1; vcount = 0;
    n_done = 0; n_sel = 0; n_to = 0; n_end = 0; end_cyc = -1;
    busy_at_end = 1'bx;
    send_idx = 0;
  endtask

  task automatic set_rdy(input logic [7:0] v);
    for (int k = 0; k < 64; k++) rdy_pat[k] = v;
  endtask

  task automatic push(input logic [139:0] rec);
    fq.push_back(rec);
    fifo_empty = 1'b0;
  endtask

  function automatic logic [139:0] mk(input logic [127:0] pl, input logic [7:0] ch, input logic [3:0] len);
    return {pl, ch, len};
  endfunction

  // One clock: drive inputs for the new cycle, then log what the DUT shows in it.
  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
    if (rd_prev) begin
      if (fq.size() > 0) fifo_dout = fq.pop_front();
      else fifo_dout = '0;
      fifo_empty = (fq.size() == 0);
    end
    rd_prev  = fifo_rd_en;
    ch_ready = rdy_pat[(send_idx < 64) ? send_idx : 63];
    if (fifo_rd_en) rd_cyc.push_back(cyc);
    if (dout_valid != 8'd0) begin
      vq.push_back({dout_valid, dout});
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
      vcount++;
      send_idx++;
    end
    if (frame_done || sel_err || timeout_err) begin
      if (frame_done)  n_done++;
      if (sel_err)     n_sel++;
      if (timeout_err) n_to++;
      n_end++;
      end_cyc     = cyc;
      busy_at_end = busy;
      send_idx    = 0;
    end
  endtask

  task automatic run_until_end(input int n, input int budget, input string tag);
    int start;
    start = cyc;
    while (n_end < n && (cyc - start) < budget) tick();
    chk({tag, "_bound"}, (n_end >= n), 1'b1);
  endtask

  // Reference: walk the ready pattern one SEND cycle at a time from the record's fields.
  task automatic check_frame(input logic [139:0] rec, input string tag);
    logic [7:0]  ch;
    logic [3:0]  len;
    logic [23:0] exp_q[$];
    int kind, sent, stall, i, nk;
    ch = rec[11:4];
    len = rec[3:0];
    sent = 0; stall = 0; i = 0;
    if (!(($countones(ch) == 1) && (len >= 1) && (len <= 8))) kind = 1;
    else begin
      kind = 0;
      while (sent < int'(len) && kind == 0) begin
        exp_q.push_back({ch, rec[139 - 16*sent -: 16]});
        if ((rdy_pat[i] & ch) != 8'd0) begin
          sent++;
          stall = 0;
        end else begin
          stall++;
          if (TB_TIMEOUT != 0 && stall == TB_TIMEOUT) kind = 2;
        end
        i++;
      end
    end
    chk({tag, "_rd_pulses"}, rd_cyc.size(), 1);
    chk({tag, "_frame_done"}, n_done, (kind == 0));
    chk({tag, "_sel_err"}, n_sel, (kind == 1));
    chk({tag, "_timeout_err"}, n_to, (kind == 2));
    chk({tag, "_valid_cycles"}, vq.size(), exp_q.size());
    nk = (vq.size() < exp_q.size()) ? vq.size() : exp_q.size();
    for (int k = 0; k < nk; k++) chk({tag, "_word"}, vq[k], exp_q[k]);
    if (rd_cyc.size() > 0 && vq.size() > 0) chk({tag, "_latency"}, first_v - rd_cyc[0], 2);
    if (n_end > 0 && rd_cyc.size() > 0)
      chk({tag, "_end_time"}, end_cyc, (kind == 1) ? rd_cyc[0] + 2 : last_v + 1);
    if (n_end > 0) chk({tag, "_busy_at_end"}, busy_at_end, (kind == 0));
  endtask

  task automatic one_frame(input logic [139:0] rec, input string tag);
    clear_log();
    push(rec);
    run_until_end(1, 200, tag);
    check_frame(rec, tag);
  endtask

  initial begin
    logic [139:0] rec_a, rec_b;
    logic [7:0]   ch;
    logic [3:0]   len;
    logic [127:0] pl;
    int guard;

    rst = 1'b1; fifo_empty = 1'b1; fifo_dout = '0; ch_ready = 8'd0;
    set_rdy(8'hFF);
    clear_log();
    tick(); tick();
    chk("reset_outputs", {dout, dout_valid, fifo_rd_en, frame_done, sel_err, timeout_err, busy}, '0);
    rst = 1'b0;
    tick(); tick();
    chk("idle_empty_no_pop", rd_cyc.size(), 0);
    chk("idle_empty_busy", busy, 1'b0);

    // single short frame
    set_rdy(8'hFF);
    one_frame(mk({16'hA1A1, 16'hB2B2, 96'h0}, 8'h04, 4'd2), "single");

    // full frame with a three-cycle stall on the selected channel
    set_rdy(8'hFF);
    for (int k = 2; k <= 4; k++) rdy_pat[k] = 8'h7F;
    one_frame(mk(128'h0001_0002_0003_0004_0005_0006_0007_0008, 8'h80, 4'd8), "stall");
    chk("stall_send_cycles", vcount, 11);

    // malformed records
    set_rdy(8'hFF);
    one_frame(mk(128'h1234, 8'h06, 4'd4), "bad_twohot");
    one_frame(mk(128'h1234, 8'h01, 4'd0), "bad_len0");
    one_frame(mk(128'h1234, 8'h01, 4'd9), "bad_len9");

    // stalled channel abandoned after TIMEOUT cycles
    set_rdy(8'h00);
    one_frame(mk({16'hC3C3, 16'hD4D4, 16'hE5E5, 80'h0}, 8'h01, 4'd3), "timeout");
    chk("timeout_valid_cycles", vcount, TB_TIMEOUT);
    tick();

    // back-to-back frames
    set_rdy(8'hFF);
    clear_log();
    push(mk({16'h1111, 112'h0}, 8'h02, 4'd1));
    push(mk({16'h2222, 112'h0}, 8'h10, 4'd1));
    run_until_end(2, 200, "b2b");
    chk("b2b_rd_count", rd_cyc.size(), 2);
    if (rd_cyc.size() == 2) chk("b2b_rd_spacing", rd_cyc[1] - rd_cyc[0], 5);
    chk("b2b_vcount", vq.size(), 2);
    if (vq.size() == 2) begin
      chk("b2b_ch0", vq[0], {8'h02, 16'h1111});
      chk("b2b_ch1", vq[1], {8'h10, 16'h2222});
    end
    chk("b2b_done_count", n_done, 2);

    // reset in the middle of SEND, then the next queued record
    set_rdy(8'hFF);
    clear_log();
    rec_a = mk(128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0101_0202, 8'h01, 4'd8);
    rec_b = mk({16'h5A5A, 16'hA5A5, 96'h0}, 8'h20, 4'd2);
    push(rec_a);
    push(rec_b);
    guard = 0;
    while (vcount < 3 && guard < 100) begin tick(); guard++; end
    chk("rst_mid_reach_send", (vcount >= 3), 1'b1);
    rst = 1'b1;
    tick();
    chk("rst_mid_outputs", {dout, dout_valid, fifo_rd_en, frame_done, sel_err, timeout_err, busy}, '0);
    rst = 1'b0;
    chk("rst_mid_no_pulse", n_end, 0);
    clear_log();
    run_until_end(1, 200, "after_rst");
    check_frame(rec_b, "after_rst");

    // randomized frames
    for (int f = 0; f < 24; f++) begin
      ch  = ($urandom_range(0, 3) != 0) ? (8'd1 << $urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      len = ($urandom_range(0, 6) != 0) ? 4'($urandom_range(1, 8)) : 4'($urandom_range(0, 15));
      pl  = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < 64; k++)
        rdy_pat[k] = (8'($urandom) & ~ch) | (($urandom_range(0, 2) != 0) ? ch : 8'd0);
      one_frame(mk(pl, ch, len), "rand");
      if ($urandom_range(0, 1) != 0) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_dispatch_ctrl.md
Name: frame_dispatch_ctrl

Overview:
Sequencer between the parsed-frame FIFO and the eight output channels. It pops one 140-bit frame record, validates the channel select and length fields, then streams the payload as 16-bit words to the selected channel using a valid/ready handshake. Malformed records are dropped and flagged. A stalled channel is abandoned after a programmable timeout.

Parameters:
TIMEOUT, 256, maximum consecutive stalled SEND cycles before the frame is dropped; 0 disables the timeout.
CNT_W, 16, width of the stall counter; must satisfy TIMEOUT < 2^CNT_W.

Ports:
clk_in  in  1  system clock; all logic is on the rising edge.
rst  in  1  synchronous reset, active-high.
fifo_empty  in  1  frame FIFO empty flag.
fifo_rd_en  out  1  FIFO pop strobe; fifo_dout is valid on the cycle after the strobe.
fifo_dout  in  140  frame record: [139:12] payload, left-justified, word0 at [139:124]; [11:4] ch_sel, one-hot; [3:0] len, in 16-bit words.
ch_ready  in  8  per-channel ready.
dout  out  16  payload word, shared by all channels.
dout_valid  out  8  one-hot valid for the target channel.
frame_done  out  1  1-cycle pulse when a frame has fully transferred.
sel_err  out  1  1-cycle pulse when a record is dropped as malformed.
timeout_err  out  1  1-cycle pulse when a frame is dropped on timeout.
busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; all outputs 0; payload register, channel register, word counter and stall counter all cleared. Reset mid-frame discards the frame; no pulse is generated.
- States: IDLE, FETCH, LATCH, SEND, DONE.
- IDLE: if fifo_empty=0, go to FETCH; otherwise stay.
- FETCH: fifo_rd_en=1 for exactly this one cycle. Go to LATCH unconditionally.
- LATCH: capture fifo_dout[139:12] into the payload register, ch_sel into the channel register and len into the word counter. Clear the stall counter.
  - Record is valid iff ch_sel has exactly one bit set AND 1 <= len <= 8.
  - Invalid: sel_err=1 in the next cycle; go to IDLE. The FIFO entry is already consumed.
  - Valid: go to SEND.
- SEND:
  - dout = payload[127:112] (top of the register); dout_valid = channel register. Neither output depends on ch_ready.
  - A transfer occurs in a cycle where ch_ready & channel register is nonzero.
  - On a transfer: shift the payload left by 16 bits; decrement the word counter; clear the stall counter. If the counter was 1, go to DONE.
  - With no transfer: increment the stall counter. If TIMEOUT!=0 and the incremented value equals TIMEOUT, timeout_err=1 in the next cycle and go to IDLE. No further words are sent.
  - ch_ready bits of non-selected channels are ignored.
- DONE: frame_done=1 for one cycle; dout_valid=0; go to IDLE.
- Outputs are Moore/registered. dout_valid, fifo_rd_en, frame_done, sel_err and timeout_err are all 0 outside the states named above.
- sel_err and timeout_err are asserted while the FSM is in IDLE, i.e. the cycle after the decision. frame_done is asserted in DONE.
- Latency: fifo_empty observed low at edge N gives fifo_rd_en high in cycle N+1, LATCH in N+2, first dout_valid in N+3. A len=L frame with ch_ready held high occupies SEND for exactly L cycles.
- Minimum frame-to-frame spacing: 4+L cycles (IDLE, FETCH, LATCH, L×SEND, DONE). IDLE does not pre-fetch.
- Back-to-back frames: DONE then IDLE then FETCH. fifo_empty is re-sampled in IDLE.
- fifo_empty is ignored outside IDLE. A FIFO that goes empty during FETCH does not affect the cycle.

Test Plan:
- Single frame, ch_sel=8'h04, len=2, payload words 16'hA1A1 then 16'hB2B2, ch_ready=8'hFF. Required: dout_valid=8'h04 for 2 cycles with dout=A1A1 then B2B2; frame_done pulses the next cycle; exactly one fifo_rd_en pulse.
- Full frame, len=8, ch_sel=8'h80. ch_ready[7] low on cycles 3-5 of SEND. Required: dout holds the word during the stall; all 8 words are delivered in order; total SEND time is 11 cycles; timeout_err=0.
- Malformed records: ch_sel=8'h06 len=4, then ch_sel=8'h01 len=0, then len=9. Required: each gives one sel_err pulse, no dout_valid and one fifo_rd_en.
- Timeout with TIMEOUT=4, ch_sel=8'h01 len=3, ch_ready=0 forever. Required: dout_valid=8'h01 for exactly 4 cycles, then timeout_err pulse, busy=0, no frame_done.
- Two frames queued (ch 8'h02 len=1, then ch 8'h10 len=1), ch_ready all high. Required: second fifo_rd_en comes 5 cycles after the first; dout_valid sequence is 8'h02 then 8'h10.
- rst=1 asserted during SEND of a len=8 frame. Required: next cycle all outputs are 0 and state is IDLE; after release, the next queued record is fetched normally.
